// File: rtl/axi_lite_ram_agent.sv
// AXI4-lite subordinate fronting a DEPTH x 32-bit RAM; independent write/read FSMs.
// Optional: define AXI_RAM_SIZE_CHECK_EN to reject non-word sizes and misaligned addresses.
module axi_lite_ram_agent #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_reset_n,
    input  logic [31:0] agent_awaddr,
    input  logic [2:0]  agent_awsize,
    input  logic [2:0]  agent_awprot,
    input  logic        agent_awvalid,
    output logic        agent_awready,
    input  logic [31:0] agent_wdata,
    input  logic [3:0]  agent_wstrb,
    input  logic        agent_wlast,
    input  logic        agent_wvalid,
    output logic        agent_wready,
    output logic [1:0]  agent_bresp,
    output logic        agent_bvalid,
    input  logic        agent_bready,
    input  logic [31:0] agent_araddr,
    input  logic [2:0]  agent_arsize,
    input  logic [2:0]  agent_arprot,
    input  logic        agent_arvalid,
    output logic        agent_arready,
    output logic [31:0] agent_rdata,
    output logic [1:0]  agent_rresp,
    output logic        agent_rvalid,
    input  logic        agent_rready
);

    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    logic [31:0] mem [DEPTH];

    wstate_e     w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [2:0]  awsize_q, awsize_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    rstate_e     r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic          wr_ok, rd_ok;
    logic [31:0]   wr_addr, wr_data, wr_off, rd_off;
    logic [3:0]    wr_strb;
    logic [2:0]    wr_size;
    logic [IW-1:0] wr_idx, rd_idx;

    assign aw_hs = agent_awvalid & awready_q;
    assign w_hs  = agent_wvalid & wready_q;
    assign ar_hs = agent_arvalid & arready_q;

    // A beat handshaking this cycle bypasses its holding register.
    assign wr_addr = aw_hs ? agent_awaddr : awaddr_q;
    assign wr_size = aw_hs ? agent_awsize : awsize_q;
    assign wr_data = w_hs ? agent_wdata : wdata_q;
    assign wr_strb = w_hs ? agent_wstrb : wstrb_q;

    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_off = agent_araddr - BASE_ADDR;
    assign wr_idx = wr_off[IW+1:2];
    assign rd_idx = rd_off[IW+1:2];

    assign commit = (w_state_q == W_IDLE)
                  & (aw_held_q | aw_hs)
                  & (w_held_q | w_hs);

`ifdef AXI_RAM_SIZE_CHECK_EN
    assign wr_ok = (wr_off < SPAN) && (wr_size == 3'b010)
                && (wr_addr[1:0] == 2'b00);
    assign rd_ok = (rd_off < SPAN) && (agent_arsize == 3'b010)
                && (agent_araddr[1:0] == 2'b00);
    logic unused_sink;
    assign unused_sink = ^{agent_awprot, agent_arprot, agent_wlast};
`else
    assign wr_ok = wr_off < SPAN;
    assign rd_ok = rd_off < SPAN;
    logic unused_sink;
    assign unused_sink = ^{agent_awprot, agent_arprot, agent_wlast,
                           wr_size, agent_arsize};
`endif

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = agent_awaddr;
                    awsize_d  = agent_awsize;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = agent_wdata;
                    wstrb_d  = agent_wstrb;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (commit) begin
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_ok ? OKAY : SLVERR;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (agent_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    // The read samples the RAM before this edge's write lands.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = rd_ok ? mem[rd_idx] : 32'h0;
                    rresp_d   = rd_ok ? OKAY : SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (agent_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= 32'h0;
            awsize_q  <= 3'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    assign agent_awready = awready_q;
    assign agent_wready  = wready_q;
    assign agent_bvalid  = bvalid_q;
    assign agent_bresp   = bresp_q;
    assign agent_arready = arready_q;
    assign agent_rvalid  = rvalid_q;
    assign agent_rresp   = rresp_q;
    assign agent_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_ram_agent.sv
// Self-checking bench for axi_lite_ram_agent: vector table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_axi_lite_ram_agent;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_reset_n;
    logic [31:0] agent_awaddr;
    logic [2:0]  agent_awsize;
    logic [2:0]  agent_awprot;
    logic        agent_awvalid;
    logic        agent_awready;
    logic [31:0] agent_wdata;
    logic [3:0]  agent_wstrb;
    logic        agent_wlast;
    logic        agent_wvalid;
    logic        agent_wready;
    logic [1:0]  agent_bresp;
    logic        agent_bvalid;
    logic        agent_bready;
    logic [31:0] agent_araddr;
    logic [2:0]  agent_arsize;
    logic [2:0]  agent_arprot;
    logic        agent_arvalid;
    logic        agent_arready;
    logic [31:0] agent_rdata;
    logic [1:0]  agent_rresp;
    logic        agent_rvalid;
    logic        agent_rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    axi_lite_ram_agent #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .reset_reset_n(reset_reset_n),
        .agent_awaddr(agent_awaddr),
        .agent_awsize(agent_awsize),
        .agent_awprot(agent_awprot),
        .agent_awvalid(agent_awvalid),
        .agent_awready(agent_awready),
        .agent_wdata(agent_wdata),
        .agent_wstrb(agent_wstrb),
        .agent_wlast(agent_wlast),
        .agent_wvalid(agent_wvalid),
        .agent_wready(agent_wready),
        .agent_bresp(agent_bresp),
        .agent_bvalid(agent_bvalid),
        .agent_bready(agent_bready),
        .agent_araddr(agent_araddr),
        .agent_arsize(agent_arsize),
        .agent_arprot(agent_arprot),
        .agent_arvalid(agent_arvalid),
        .agent_arready(agent_arready),
        .agent_rdata(agent_rdata),
        .agent_rresp(agent_rresp),
        .agent_rvalid(agent_rvalid),
        .agent_rready(agent_rready)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain address arithmetic over a word array.
    function automatic bit m_in(input logic [31:0] a);
        longint unsigned x, lo, hi;
        x  = longint'(a);
        lo = longint'(BASE);
        hi = lo + longint'(DEPTH) * 4;
        return (x >= lo) && (x < hi);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return m_in(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_in(a) ? model[m_idx(a)] : 32'h0;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        if (m_in(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[m_idx(a)][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic start_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int awd,
                               input int wd);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0;
        w_done = 0;
        cyc = 0;
        agent_awaddr = a;
        agent_wdata = d;
        agent_wstrb = s;
        while (!(aw_done && w_done) && cyc < 64) begin
            agent_awvalid = !aw_done && cyc >= awd;
            agent_wvalid = !w_done && cyc >= wd;
            aw_hs = agent_awvalid && agent_awready;
            w_hs = agent_wvalid && agent_wready;
            @(posedge clk);
            #1;
            aw_done |= aw_hs;
            w_done |= w_hs;
            if (w_hs && !aw_done) check("wready_drop", agent_wready, 0);
            if (aw_hs && !w_done) check("awready_drop", agent_awready, 0);
            cyc++;
        end
        agent_awvalid = 0;
        agent_wvalid = 0;
        check("write_hs_done", {aw_done, w_done}, 2'b11);
        check("bvalid_latency", agent_bvalid, 1);
    endtask

    task automatic finish_write(input int dly, input logic [1:0] exp);
        check("bresp", agent_bresp, exp);
        for (int k = 0; k < dly; k++) begin
            @(posedge clk);
            #1;
            check("bvalid_hold", agent_bvalid, 1);
            check("bresp_hold", agent_bresp, exp);
            check("aw_w_ready_low", {agent_awready, agent_wready}, 2'b00);
        end
        agent_bready = 1;
        @(posedge clk);
        #1;
        agent_bready = 0;
        check("bvalid_clear", agent_bvalid, 0);
        check("aw_w_ready_back", {agent_awready, agent_wready}, 2'b11);
    endtask

    task automatic start_read(input logic [31:0] a);
        bit done, hs;
        int cyc;
        done = 0;
        cyc = 0;
        agent_araddr = a;
        while (!done && cyc < 64) begin
            agent_arvalid = 1;
            hs = agent_arready;
            @(posedge clk);
            #1;
            done = hs;
            cyc++;
        end
        agent_arvalid = 0;
        check("read_hs_done", done, 1);
        check("rvalid_latency", agent_rvalid, 1);
        check("arready_drop", agent_arready, 0);
    endtask

    task automatic finish_read(input int dly, input logic [31:0] exp_d,
                               input logic [1:0] exp_r);
        check("rdata", agent_rdata, exp_d);
        check("rresp", agent_rresp, exp_r);
        for (int k = 0; k < dly; k++) begin
            @(posedge clk);
            #1;
            check("rvalid_hold", agent_rvalid, 1);
            check("rdata_hold", agent_rdata, exp_d);
            check("arready_low", agent_arready, 0);
        end
        agent_rready = 1;
        @(posedge clk);
        #1;
        agent_rready = 0;
        check("rvalid_clear", agent_rvalid, 0);
        check("arready_back", agent_arready, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int awd, input int wd,
                      input int bd);
        start_write(a, d, s, awd, wd);
        m_write(a, d, s);
        finish_write(bd, m_resp(a));
    endtask

    task automatic rd(input logic [31:0] a, input int dly);
        start_read(a);
        finish_read(dly, m_read(a), m_resp(a));
    endtask

    typedef struct {
        logic [31:0] off;
        logic [31:0] data;
        logic [3:0]  strb;
        int          awd;
        int          wd;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  br;

        vt[0] = '{32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00};
        vt[1] = '{32'h20, 32'h12345678, 4'hF, 0, 0, 2'b00, 32'h12345678, 2'b00};
        vt[2] = '{32'h20, 32'h000000AA, 4'h1, 3, 0, 2'b00, 32'h123456AA, 2'b00};
        vt[3] = '{32'h20, 32'hBB000000, 4'h8, 0, 2, 2'b00, 32'hBB3456AA, 2'b00};
        vt[4] = '{32'h20, 32'hFFFFFFFF, 4'h0, 1, 1, 2'b00, 32'hBB3456AA, 2'b00};
        vt[5] = '{32'h22, 32'h0000CC00, 4'h2, 2, 2, 2'b00, 32'hBB34CCAA, 2'b00};
        vt[6] = '{32'hFC, 32'hCAFEF00D, 4'hF, 0, 0, 2'b00, 32'hCAFEF00D, 2'b00};
        vt[7] = '{32'h100, 32'h11111111, 4'hF, 0, 0, 2'b10, 32'h0, 2'b10};
        vt[8] = '{32'hFFFFFFFC, 32'h22222222, 4'hF, 1, 0, 2'b10, 32'h0, 2'b10};

        reset_reset_n = 0;
        agent_awaddr = 0; agent_awsize = 3'b010; agent_awprot = 0;
        agent_awvalid = 0; agent_wdata = 0; agent_wstrb = 0;
        agent_wlast = 1; agent_wvalid = 0; agent_bready = 0;
        agent_araddr = 0; agent_arsize = 3'b010; agent_arprot = 0;
        agent_arvalid = 0; agent_rready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl",
              {agent_awready, agent_wready, agent_arready,
               agent_bvalid, agent_rvalid}, 5'b0);
        check("reset_resp", {agent_bresp, agent_rresp}, 4'b0);
        check("reset_rdata", agent_rdata, 32'h0);
        @(negedge clk);
        reset_reset_n = 1;
        #1;
        check("ready_pre_edge",
              {agent_awready, agent_wready, agent_arready}, 3'b000);
        @(posedge clk);
        #1;
        check("ready_first_edge",
              {agent_awready, agent_wready, agent_arready}, 3'b111);

        for (int i = 0; i < DEPTH; i++)
            wr(BASE + 32'(i * 4), $urandom, 4'hF, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            a = BASE + vt[i].off;
            start_write(a, vt[i].data, vt[i].strb, vt[i].awd, vt[i].wd);
            m_write(a, vt[i].data, vt[i].strb);
            finish_write(0, vt[i].bresp);
            start_read(a);
            finish_read(0, vt[i].rdata, vt[i].rresp);
        end
        rd(BASE, 0);
        start_read(BASE + 32'hFC);
        finish_read(0, 32'hCAFEF00D, 2'b00);

        // bready held low while a read runs alongside
        start_write(BASE + 32'h40, 32'h0BADF00D, 4'hF, 0, 0);
        m_write(BASE + 32'h40, 32'h0BADF00D, 4'hF);
        rd(BASE + 32'h44, 1);
        check("bvalid_during_read", agent_bvalid, 1);
        finish_write(5, 2'b00);
        // rready held low while a write runs alongside
        start_read(BASE + 32'h40);
        wr(BASE + 32'h48, 32'h600DCAFE, 4'hF, 1, 0, 1);
        finish_read(5, 32'h0BADF00D, 2'b00);
        rd(BASE + 32'h48, 0);

        // same-edge write and read of one word
        wr(BASE + 32'h30, 32'hAAAAAAAA, 4'hF, 0, 0, 0);
        agent_awaddr = BASE + 32'h30;
        agent_araddr = BASE + 32'h30;
        agent_wdata = 32'h55555555;
        agent_wstrb = 4'hF;
        agent_awvalid = 1; agent_wvalid = 1; agent_arvalid = 1;
        @(posedge clk);
        #1;
        agent_awvalid = 0; agent_wvalid = 0; agent_arvalid = 0;
        check("same_edge_valids", {agent_bvalid, agent_rvalid}, 2'b11);
        finish_read(0, 32'hAAAAAAAA, 2'b00);
        m_write(BASE + 32'h30, 32'h55555555, 4'hF);
        finish_write(0, 2'b00);
        start_read(BASE + 32'h30);
        finish_read(0, 32'h55555555, 2'b00);

        // reset while both paths hold a response
        start_write(BASE + 32'h50, 32'h13579BDF, 4'hF, 0, 0);
        m_write(BASE + 32'h50, 32'h13579BDF, 4'hF);
        start_read(BASE + 32'h10);
        #2;
        reset_reset_n = 0;
        #1;
        check("midreset_ctrl",
              {agent_awready, agent_wready, agent_arready,
               agent_bvalid, agent_rvalid}, 5'b0);
        check("midreset_data", {agent_bresp, agent_rresp, agent_rdata}, 36'h0);
        @(posedge clk);
        @(negedge clk);
        reset_reset_n = 1;
        @(posedge clk);
        #1;
        check("ready_after_midreset",
              {agent_awready, agent_wready, agent_arready}, 3'b111);
        rd(BASE + 32'h50, 0);
        wr(BASE + 32'h54, 32'h2468ACE0, 4'hF, 0, 0, 0);
        rd(BASE + 32'h54, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    a = BASE + (32'(DEPTH) * 4) + 32'($urandom_range(0, 63) * 4);
                else
                    a = BASE - 32'($urandom_range(1, 64) * 4);
            end else begin
                a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4)
                         + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                br = m_resp(a);
                start_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
                m_write(a, d, s);
                finish_write($urandom_range(0, 2), br);
            end else begin
                rd(a, $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram_agent.md
Name: axi_lite_ram_agent

Overview:
- AXI4-lite subordinate (responder) with a DEPTH x 32-bit on-chip RAM behind it.
- Connects to the processor's data_manager or instruction_manager AXI-lite initiator port.
- Serves the processor's single-beat read and write transactions with OKAY or SLVERR responses.
- Write path and read path run as independent FSMs; each allows one outstanding transaction.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH*4 aligned.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- agent_awaddr  in  32  write byte address.
- agent_awsize  in  3  write size; only 3'b010 (4 bytes) is legal.
- agent_awprot  in  3  protection; accepted and ignored.
- agent_awvalid  in  1  write address valid.
- agent_awready  out  1  write address ready.
- agent_wdata  in  32  write data.
- agent_wstrb  in  4  byte strobes; bit i enables byte lane i.
- agent_wlast  in  1  ignored; every burst is one beat.
- agent_wvalid  in  1  write data valid.
- agent_wready  out  1  write data ready.
- agent_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- agent_bvalid  out  1  write response valid.
- agent_bready  in  1  write response ready.
- agent_araddr  in  32  read byte address.
- agent_arsize  in  3  read size; only 3'b010 is legal.
- agent_arprot  in  3  accepted and ignored.
- agent_arvalid  in  1  read address valid.
- agent_arready  out  1  read address ready.
- agent_rdata  out  32  read data.
- agent_rresp  out  2  read response.
- agent_rvalid  out  1  read response valid.
- agent_rready  in  1  read response ready.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0: ready signals, bvalid, rvalid, bresp, rresp, rdata.
  - Both FSMs go to IDLE; AW/W capture flags clear.
  - RAM contents are not reset.
- Ready timing: all ready outputs are registered and go to 1 on the first clk edge after reset is released.
- Address decode: off = addr - BASE_ADDR (32-bit wrap); in range iff off < DEPTH*4; word index = off[log2(DEPTH)+1:2]; addr[1:0] ignored.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready = !aw_captured, wready = !w_captured.
  - AW and W handshakes are independent, in either order or the same cycle; each is latched into a holding register on handshake.
  - Commit: on the edge where both are held, or both handshake together, write the byte lanes with wstrb=1 if in range.
  - Same edge: bvalid=1, bresp set, awready=wready=0, go to W_RESP.
  - Minimum latency: AW+W handshake at edge N gives bvalid high after edge N.
  - Out of range: no RAM write, bresp=2'b10.
  - wstrb=4'b0000 in range: no bytes change, bresp=OKAY.
  - W_RESP: hold bvalid and bresp stable until bready. On the bvalid&&bready edge: bvalid=0, clear flags, go to W_IDLE, restore readies on the same edge.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1.
  - On the ar handshake edge: rdata = RAM[index] (or 0 if out of range), rresp = OKAY or SLVERR, rvalid=1, arready=0, go to R_RESP.
  - R_RESP: hold rdata, rresp and rvalid until rready. On the handshake edge: rvalid=0, arready=1, go to R_IDLE.
- Write and read on the same edge to the same word: the read returns the pre-write data. The write commits on the same edge and the new data is visible to later reads.
- valid without ready: the subordinate never drops ready while waiting; initiator-side valid stability is the initiator's duty.
- No combinational paths from any input to any output.

Optional Feature:
- Macro: AXI_RAM_SIZE_CHECK_EN.
- Defined:
  - awsize != 3'b010 gives no write and bresp=2'b10.
  - arsize != 3'b010 gives rdata=0 and rresp=2'b10.
  - Misaligned addr[1:0] != 0 gives SLVERR with no write or read.
  - Same timing as the in-range cases.
- Undefined: awsize, arsize and addr[1:0] are ignored, and every in-range access returns OKAY.

Test Plan:
1. Reset, then write 0xDEADBEEF to BASE+0x10 with wstrb=4'hF, AW and W in the same cycle -> bresp=00 one cycle later. Then read BASE+0x10 -> rdata=0xDEADBEEF, rresp=00, rvalid one cycle after the ar handshake.
2. W sent 3 cycles before AW, wdata=0x000000AA, wstrb=4'b0001, to a word holding 0x12345678 -> wready drops after the W handshake; bvalid follows the AW handshake; a later read gives 0x123456AA.
3. Write to BASE+DEPTH*4 (first out-of-range address) -> bresp=10 and RAM unchanged. Read the same address -> rdata=0, rresp=10.
4. bready held 0 for 5 cycles -> bvalid and bresp stable, awready and wready 0 throughout, and a concurrent read still completes. Repeat for rready held low with a concurrent write.
5. Same-edge write of 0x5555_5555 and read of the same word, which holds 0xAAAA_AAAA -> rdata=0xAAAA_AAAA; the next read returns 0x5555_5555.
6. Assert reset_reset_n=0 while in W_RESP and R_RESP -> bvalid, rvalid and all readies go to 0 immediately. After release, readies go to 1 on the first edge and a fresh transaction succeeds.
